one_shot_scheduler: RTL and testbench

Round-robin scheduler that shares one one_shot pulse generator among N_REQ requesters. The scheduler latches the winner's duration, then drives the one-shot's dur/load/in controls. It monitors the one-shot's out level through its rise and fall, returns a done pulse to the winner, and enforces an idle gap before the next grant. Bounded timeouts protect against a stuck or silent one-shot.

---
 rtl/one_shot_scheduler.sv | 163 ++++++++++++++++
 tb/tb_one_shot_scheduler.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/one_shot_scheduler.sv
// Round-robin arbiter that time-shares a single one-shot pulse generator.
// It loads and fires the one-shot, watches its output with timeouts, then returns done.
module one_shot_scheduler #(
  parameter int N_REQ   = 4,
  parameter int DUR_W   = 8,
  parameter int TIMEOUT = 15,
  parameter int GAP     = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*DUR_W-1:0] dur_in,
  output logic [N_REQ-1:0]       grant,
  output logic [N_REQ-1:0]       done,
  output logic                   err,
  output logic                   busy,
  output logic [DUR_W-1:0]       os_dur,
  output logic                   os_load,
  output logic                   os_in,
  input  logic                   os_out
);

  // state   | meaning
  // IDLE    | waiting for a request; winner and duration latched on exit
  // LOAD    | grant and os_load presented with os_dur
  // FIRE    | os_in pulse, or immediate done for a zero duration
  // WAIT_HI | waiting for os_out to rise, TIMEOUT-cycle bound
  // WAIT_LO | waiting for os_out to fall, dur_q+TIMEOUT-cycle bound
  // GAP     | enforced idle gap between services

  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int TW = DUR_W + 5;
  localparam int GW = $clog2(GAP + 2);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_FIRE, S_WAIT_HI, S_WAIT_LO, S_GAP
  } state_t;

  state_t            state;
  logic [PW-1:0]     rr_ptr;
  logic [PW-1:0]     win;
  logic [DUR_W-1:0]  dur_q;
  logic [TW-1:0]     tmr;
  logic [GW-1:0]     gcnt;

  logic [PW-1:0]     pick_idx;
  logic [PW-1:0]     cand;
  logic [PW-1:0]     next_rr;
  logic [DUR_W-1:0]  pick_dur;

  // Scan downward so the candidate closest to rr_ptr is written last and wins.
  always_comb begin
    pick_idx = rr_ptr;
    cand     = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      cand = PW'((int'(rr_ptr) + i) % N_REQ);
      if (req[cand]) pick_idx = cand;
    end
  end

  always_comb begin
    pick_dur = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (PW'(i) == pick_idx) pick_dur = dur_in[i*DUR_W +: DUR_W];
    end
    if (int'(pick_idx) == N_REQ - 1) next_rr = '0;
    else                             next_rr = pick_idx + 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= S_IDLE;
      rr_ptr  <= '0;
      win     <= '0;
      dur_q   <= '0;
      tmr     <= '0;
      gcnt    <= '0;
      grant   <= '0;
      done    <= '0;
      err     <= 1'b0;
      busy    <= 1'b0;
      os_dur  <= '0;
      os_load <= 1'b0;
      os_in   <= 1'b0;
    end else begin
      done <= '0;
      err  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (|req) begin
            win    <= pick_idx;
            dur_q  <= pick_dur;
            rr_ptr <= next_rr;
            busy   <= 1'b1;
            state  <= S_LOAD;
          end
        end
        S_LOAD: begin
          grant   <= N_REQ'(1) << win;
          os_dur  <= dur_q;
          os_load <= (dur_q != '0);
          state   <= S_FIRE;
        end
        S_FIRE: begin
          os_load <= 1'b0;
          if (dur_q == '0) begin
            done  <= grant;
            grant <= '0;
            gcnt  <= GW'(GAP);
            state <= S_GAP;
          end else begin
            os_in <= 1'b1;
            tmr   <= TW'(TIMEOUT);
            state <= S_WAIT_HI;
          end
        end
        S_WAIT_HI: begin
          os_in <= 1'b0;
          if (os_out) begin
            tmr   <= TW'(dur_q) + TW'(TIMEOUT);
            state <= S_WAIT_LO;
          end else if (tmr <= TW'(1)) begin
            err   <= 1'b1;
            done  <= grant;
            grant <= '0;
            gcnt  <= GW'(GAP);
            state <= S_GAP;
          end else begin
            tmr <= tmr - 1'b1;
          end
        end
        S_WAIT_LO: begin
          if (!os_out) begin
            done  <= grant;
            grant <= '0;
            gcnt  <= GW'(GAP);
            state <= S_GAP;
          end else if (tmr <= TW'(1)) begin
            err   <= 1'b1;
            done  <= grant;
            grant <= '0;
            gcnt  <= GW'(GAP);
            state <= S_GAP;
          end else begin
            tmr <= tmr - 1'b1;
          end
        end
        S_GAP: begin
          // GAP of 0 or 1 both leave after a single cycle here.
          if (gcnt <= GW'(1)) begin
            busy   <= 1'b0;
            os_dur <= '0;
            state  <= S_IDLE;
          end else begin
            gcnt <= gcnt - 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_one_shot_scheduler.sv
// Directed bench for one_shot_scheduler with a behavioural one-shot that can
// also be forced stuck-low or stuck-high.
module tb_one_shot_scheduler;

  logic        clk;
  logic        reset;
  logic [3:0]  req;
  logic [31:0] dur_in;
  logic [3:0]  grant;
  logic [3:0]  done;
  logic        err;
  logic        busy;
  logic [7:0]  os_dur;
  logic        os_load;
  logic        os_in;
  logic        os_out;

  int n_pass = 0;
  int n_total = 0;
  int mode = 0;  // 0 behavioural, 1 stuck low, 2 stuck high

  logic [7:0]  m_d;
  logic [7:0]  m_cnt;
  logic        m_stuck;
  logic [19:0] obs;

  one_shot_scheduler #(.N_REQ(4), .DUR_W(8), .TIMEOUT(15), .GAP(2)) dut (
    .clk(clk), .reset(reset), .req(req), .dur_in(dur_in),
    .grant(grant), .done(done), .err(err), .busy(busy),
    .os_dur(os_dur), .os_load(os_load), .os_in(os_in), .os_out(os_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One-shot: output rises the cycle after os_in and stays high for the loaded duration.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_d     <= '0;
      m_cnt   <= '0;
      m_stuck <= 1'b0;
    end else begin
      if (os_load) begin
        m_d     <= os_dur;
        m_stuck <= 1'b0;
      end
      if (os_in) begin
        m_cnt   <= m_d;
        m_stuck <= 1'b1;
      end else if (m_cnt != 0) begin
        m_cnt <= m_cnt - 1'b1;
      end
    end
  end

  assign os_out = (mode == 0) ? (m_cnt != 0) : (mode == 2) ? m_stuck : 1'b0;
  assign obs = {grant, done, err, busy, os_load, os_in, os_dur};

  task automatic do_reset();
    reset = 1'b1;
    req = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic wait_idle(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!busy) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    req = '0;
    dur_in = '0;
    #1;
    n_total++;
    if (obs !== 20'd0) $display("FAIL reset_outputs obs=%h exp=%h", obs, 20'd0);
    else n_pass++;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_single();
    logic [19:0] exp_v [1:9];
    exp_v[1] = {12'b0000_0000_0100, 8'd0};
    exp_v[2] = {12'b0001_0000_0110, 8'd2};
    exp_v[3] = {12'b0001_0000_0101, 8'd2};
    exp_v[4] = {12'b0001_0000_0100, 8'd2};
    exp_v[5] = {12'b0001_0000_0100, 8'd2};
    exp_v[6] = {12'b0001_0000_0100, 8'd2};
    exp_v[7] = {12'b0000_0001_0100, 8'd2};
    exp_v[8] = {12'b0000_0000_0100, 8'd2};
    exp_v[9] = {12'b0000_0000_0000, 8'd0};
    do_reset();
    mode = 0;
    dur_in = '0;
    dur_in[7:0] = 8'd2;
    req = 4'b0001;
    for (int n = 1; n <= 9; n++) begin
      @(negedge clk);
      if (n == 1) req = '0;
      n_total++;
      if (obs !== exp_v[n]) $display("FAIL single n=%0d obs=%h exp=%h", n, obs, exp_v[n]);
      else n_pass++;
    end
  endtask

  task automatic test_zero_dur();
    logic [19:0] exp_v [1:5];
    exp_v[1] = {12'b0000_0000_0100, 8'd0};
    exp_v[2] = {12'b0100_0000_0100, 8'd0};
    exp_v[3] = {12'b0000_0100_0100, 8'd0};
    exp_v[4] = {12'b0000_0000_0100, 8'd0};
    exp_v[5] = {12'b0000_0000_0000, 8'd0};
    do_reset();
    dur_in = {8'd7, 8'd0, 8'd7, 8'd7};
    req = 4'b0100;
    for (int n = 1; n <= 5; n++) begin
      @(negedge clk);
      if (n == 1) req = '0;
      n_total++;
      if (obs !== exp_v[n]) $display("FAIL zero_dur n=%0d obs=%h exp=%h", n, obs, exp_v[n]);
      else n_pass++;
    end
  endtask

  task automatic test_round_robin();
    logic [3:0] order [0:4];
    logic [3:0] exp_order [0:4];
    logic [3:0] prev_g;
    int done_cnt [0:3];
    int ng;
    bit err_seen, multi_grant, ok;
    exp_order[0] = 4'b0001; exp_order[1] = 4'b0010; exp_order[2] = 4'b0100;
    exp_order[3] = 4'b1000; exp_order[4] = 4'b0001;
    for (int i = 0; i < 4; i++) done_cnt[i] = 0;
    for (int i = 0; i < 5; i++) order[i] = '0;
    ng = 0; err_seen = 0; multi_grant = 0; prev_g = '0;
    do_reset();
    mode = 0;
    dur_in = {8'd4, 8'd3, 8'd2, 8'd1};
    req = 4'b1111;
    for (int c = 0; c < 300 && ng < 5; c++) begin
      @(negedge clk);
      if (grant != 0 && prev_g == 0) begin
        order[ng] = grant;
        ng++;
      end
      for (int i = 0; i < 4; i++) if (done[i]) done_cnt[i]++;
      if (err) err_seen = 1;
      if (!$onehot0(grant)) multi_grant = 1;
      prev_g = grant;
    end
    req = '0;
    n_total++;
    if (ng !== 5) $display("FAIL rr_grant_count got=%0d exp=5", ng);
    else n_pass++;
    for (int i = 0; i < 5; i++) begin
      n_total++;
      if (order[i] !== exp_order[i]) $display("FAIL rr_order idx=%0d got=%b exp=%b", i, order[i], exp_order[i]);
      else n_pass++;
    end
    for (int i = 0; i < 4; i++) begin
      n_total++;
      if (done_cnt[i] !== 1) $display("FAIL rr_done_count req=%0d got=%0d exp=1", i, done_cnt[i]);
      else n_pass++;
    end
    n_total++;
    if (err_seen !== 1'b0) $display("FAIL rr_no_err got=%b exp=0", err_seen);
    else n_pass++;
    n_total++;
    if (multi_grant !== 1'b0) $display("FAIL rr_onehot got=%b exp=0", multi_grant);
    else n_pass++;
    wait_idle(ok);
    n_total++;
    if (ok !== 1'b1) $display("FAIL rr_idle_timeout busy=%b exp=0", busy);
    else n_pass++;
  endtask

  task automatic test_stuck_low();
    bit ok;
    do_reset();
    mode = 1;
    dur_in = '0;
    dur_in[15:8] = 8'd5;
    req = 4'b0010;
    for (int n = 1; n <= 21; n++) begin
      @(negedge clk);
      if (n == 1) req = '0;
      case (n)
        3:  begin n_total++; if (obs !== {12'b0010_0000_0101, 8'd5}) $display("FAIL stuck_low_fire obs=%h exp=%h", obs, {12'b0010_0000_0101, 8'd5}); else n_pass++; end
        17: begin n_total++; if (obs !== {12'b0010_0000_0100, 8'd5}) $display("FAIL stuck_low_pre obs=%h exp=%h", obs, {12'b0010_0000_0100, 8'd5}); else n_pass++; end
        18: begin n_total++; if (obs !== {12'b0000_0010_1100, 8'd5}) $display("FAIL stuck_low_err obs=%h exp=%h", obs, {12'b0000_0010_1100, 8'd5}); else n_pass++; end
        19: begin n_total++; if (obs !== {12'b0000_0000_0100, 8'd5}) $display("FAIL stuck_low_gap obs=%h exp=%h", obs, {12'b0000_0000_0100, 8'd5}); else n_pass++; end
        21: begin n_total++; if (obs !== 20'd0) $display("FAIL stuck_low_idle obs=%h exp=%h", obs, 20'd0); else n_pass++; end
        default: ;
      endcase
    end
    // rr pointer now past requester 1: of {0,2}, requester 2 must win.
    mode = 0;
    dur_in = {8'd1, 8'd1, 8'd1, 8'd1};
    req = 4'b0101;
    repeat (2) @(negedge clk);
    req = '0;
    n_total++;
    if (grant !== 4'b0100) $display("FAIL stuck_low_rr_advance grant=%b exp=0100", grant);
    else n_pass++;
    wait_idle(ok);
    n_total++;
    if (ok !== 1'b1) $display("FAIL stuck_low_idle_timeout busy=%b exp=0", busy);
    else n_pass++;
  endtask

  task automatic test_stuck_high();
    do_reset();
    mode = 2;
    dur_in = '0;
    dur_in[7:0] = 8'd3;
    req = 4'b0001;
    for (int n = 1; n <= 26; n++) begin
      @(negedge clk);
      if (n == 1) req = '0;
      case (n)
        3:  begin n_total++; if (obs !== {12'b0001_0000_0101, 8'd3}) $display("FAIL stuck_high_fire obs=%h exp=%h", obs, {12'b0001_0000_0101, 8'd3}); else n_pass++; end
        22: begin n_total++; if (obs !== {12'b0001_0000_0100, 8'd3}) $display("FAIL stuck_high_pre obs=%h exp=%h", obs, {12'b0001_0000_0100, 8'd3}); else n_pass++; end
        23: begin n_total++; if (obs !== {12'b0000_0001_1100, 8'd3}) $display("FAIL stuck_high_err obs=%h exp=%h", obs, {12'b0000_0001_1100, 8'd3}); else n_pass++; end
        24: begin n_total++; if (obs !== {12'b0000_0000_0100, 8'd3}) $display("FAIL stuck_high_gap obs=%h exp=%h", obs, {12'b0000_0000_0100, 8'd3}); else n_pass++; end
        26: begin n_total++; if (obs !== 20'd0) $display("FAIL stuck_high_idle obs=%h exp=%h", obs, 20'd0); else n_pass++; end
        default: ;
      endcase
    end
    mode = 0;
  endtask

  task automatic test_reset_mid_service();
    bit stray, ok;
    stray = 0;
    do_reset();
    mode = 0;
    dur_in = '0;
    dur_in[15:8] = 8'd10;
    req = 4'b0010;
    for (int n = 1; n <= 6; n++) begin
      @(negedge clk);
      if (n == 1) req = '0;
    end
    n_total++;
    if (grant !== 4'b0010 || os_out !== 1'b1) $display("FAIL mid_reset_setup grant=%b os_out=%b exp=0010/1", grant, os_out);
    else n_pass++;
    reset = 1'b1;
    #1;
    n_total++;
    if (obs !== 20'd0) $display("FAIL mid_reset_outputs obs=%h exp=%h", obs, 20'd0);
    else n_pass++;
    @(negedge clk);
    reset = 1'b0;
    for (int n = 0; n < 15; n++) begin
      @(negedge clk);
      if (done != 0 || err || busy) stray = 1;
    end
    n_total++;
    if (stray !== 1'b0) $display("FAIL mid_reset_no_done got=%b exp=0", stray);
    else n_pass++;
    // rr back at 0: of {0,2}, requester 0 must win.
    dur_in = {8'd1, 8'd1, 8'd1, 8'd1};
    req = 4'b0101;
    repeat (2) @(negedge clk);
    req = '0;
    n_total++;
    if (grant !== 4'b0001) $display("FAIL mid_reset_rr_zero grant=%b exp=0001", grant);
    else n_pass++;
    wait_idle(ok);
    n_total++;
    if (ok !== 1'b1) $display("FAIL mid_reset_idle_timeout busy=%b exp=0", busy);
    else n_pass++;
  endtask

  task automatic test_dropped_req();
    do_reset();
    mode = 0;
    dur_in = '0;
    dur_in[15:8] = 8'd2;
    req = 4'b0010;
    for (int n = 1; n <= 9; n++) begin
      @(negedge clk);
      if (n == 1) req = '0;
      case (n)
        4: begin n_total++; if (grant !== 4'b0010) $display("FAIL drop_grant_held grant=%b exp=0010", grant); else n_pass++; end
        6: begin n_total++; if (done !== 4'b0000) $display("FAIL drop_done_early done=%b exp=0000", done); else n_pass++; end
        7: begin n_total++; if (done !== 4'b0010 || err !== 1'b0) $display("FAIL drop_done done=%b err=%b exp=0010/0", done, err); else n_pass++; end
        9: begin n_total++; if (busy !== 1'b0) $display("FAIL drop_idle busy=%b exp=0", busy); else n_pass++; end
        default: ;
      endcase
    end
  endtask

  initial begin
    reset = 1'b0;
    req = '0;
    dur_in = '0;
    test_reset();
    test_single();
    test_zero_dur();
    test_round_robin();
    test_stuck_low();
    test_stuck_high();
    test_reset_mid_service();
    test_dropped_req();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
